uart_img_pack_wr: RTL and testbench

//  Packs the UART receiver's byte stream (rx_data/Rx_Done) into DATA_W-bit pixel words.

---
 rtl/uart_img_pack_wr_pkg.sv | 20 ++
 rtl/uart_img_pack_wr_if.sv | 27 ++
 rtl/uart_img_pack_wr_rx_idle_timer.sv | 33 +++
 rtl/uart_img_pack_wr.sv | 109 ++++++++++
 tb/tb_uart_img_pack_wr.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_img_pack_wr_pkg.sv
// Shared constants and helpers for the UART-to-frame-RAM pixel packer.
package uart_img_pkg;

   localparam int unsigned BYTE_W           = 8;
   localparam int unsigned DEF_DATA_W       = 16;
   localparam int unsigned DEF_ADDR_W       = 16;
   localparam int unsigned DEF_FRAME_WORDS  = 16384;
   localparam int unsigned DEF_IDLE_TIMEOUT = 50000;

   // Smallest r with 2**r >= v (0 for v <= 1).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_img_pack_wr_if.sv
// Byte-stream input and frame-RAM write port of the pixel packer.
interface uart_img_pack_wr_if
   import uart_img_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic [BYTE_W-1:0] rx_data;
   logic              Rx_Done;
   logic              clr;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [DATA_W-1:0] ram_wr_data;
   logic              frame_done;
   logic              sync_err;
   logic              busy;

   modport master (
      output rx_data, Rx_Done, clr,
      input  ram_wr_en, ram_wr_addr, ram_wr_data, frame_done, sync_err, busy
   );

   modport slave (
      input  rx_data, Rx_Done, clr,
      output ram_wr_en, ram_wr_addr, ram_wr_data, frame_done, sync_err, busy
   );
endinterface

// File: rtl/uart_img_pack_wr_rx_idle_timer.sv
// Counts Clk cycles without a received byte; flags the cycle the silence limit is reached.
module rx_idle_timer
   import uart_img_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic i_enable,
   input  logic i_restart,
   output logic o_timeout_c
);
   localparam int unsigned CNT_W = (clog2(IDLE_TIMEOUT + 1) > 0) ? clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IDLE_TIMEOUT - 1);
   localparam bit TIMER_ON = (IDLE_TIMEOUT != 0);

   logic [CNT_W-1:0] r_idle_cnt;
   logic             w_at_last;

   assign w_at_last   = (r_idle_cnt == LAST_CNT);
   // A byte arriving in the limit cycle cancels the timeout.
   assign o_timeout_c = TIMER_ON && i_enable && !i_restart && w_at_last;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_idle_cnt <= '0;
      end else if (!i_enable || i_restart || w_at_last) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/uart_img_pack_wr.sv
// Packs received UART bytes into DATA_W-bit words and writes them to sequential
// frame-RAM addresses, with frame-complete, sync clear and idle-timeout resync.
module uart_img_pack_wr
   import uart_img_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned FRAME_WORDS  = DEF_FRAME_WORDS,
   parameter bit          MSB_FIRST    = 1'b1,
   parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input logic              Clk,
   input logic              Reset_n,
   uart_img_pack_wr_if.slave bus
);
   localparam int unsigned BPW    = DATA_W / BYTE_W;
   localparam int unsigned BIDX_W = (BPW > 1) ? clog2(BPW) : 1;
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

   logic [DATA_W-1:0] r_shift;
   logic [BIDX_W-1:0] r_byte_idx;
   logic [ADDR_W-1:0] r_word_cnt;
   logic              r_busy;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_frame_done;
   logic              r_sync_err;
   logic [DATA_W-1:0] w_word;
   logic              w_timeout;

   // Shift register with the current byte merged in, in the selected byte order.
   always_comb begin
      w_word = '0;
      if (MSB_FIRST) begin
         w_word = (r_shift << BYTE_W) | DATA_W'(bus.rx_data);
      end else begin
         w_word = (r_shift >> BYTE_W) | (DATA_W'(bus.rx_data) << (DATA_W - BYTE_W));
      end
   end

   rx_idle_timer #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) u_idle_timer (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .i_enable    (r_busy),
      .i_restart   (bus.Rx_Done | bus.clr),
      .o_timeout_c (w_timeout)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_shift      <= '0;
         r_byte_idx   <= '0;
         r_word_cnt   <= '0;
         r_busy       <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
         if (bus.clr) begin
            // Held write address/data are left untouched.
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_busy     <= 1'b0;
         end else if (bus.Rx_Done) begin
            r_busy <= 1'b1;
            if (r_byte_idx == LAST_BYTE) begin
               r_wr_en    <= 1'b1;
               r_wr_addr  <= r_word_cnt;
               r_wr_data  <= w_word;
               r_shift    <= '0;
               r_byte_idx <= '0;
               if (r_word_cnt == LAST_WORD) begin
                  r_word_cnt   <= '0;
                  r_frame_done <= 1'b1;
                  r_busy       <= 1'b0;
               end else begin
                  r_word_cnt <= r_word_cnt + ADDR_W'(1);
               end
            end else begin
               r_shift    <= w_word;
               r_byte_idx <= r_byte_idx + BIDX_W'(1);
            end
         end else if (w_timeout) begin
            r_sync_err <= (r_byte_idx != '0);
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_busy     <= 1'b0;
         end
      end
   end

   assign bus.ram_wr_en   = r_wr_en;
   assign bus.ram_wr_addr = r_wr_addr;
   assign bus.ram_wr_data = r_wr_data;
   assign bus.frame_done  = r_frame_done;
   assign bus.sync_err    = r_sync_err;
   assign bus.busy        = r_busy;
endmodule

// File: tb/tb_uart_img_pack_wr.sv
// Directed bench: 16-bit MSB-first packer with a 4-word frame and 100-cycle timeout,
// plus a 32-bit LSB-first packer with the timeout disabled.
module tb_uart_img_pack_wr;
   logic clk;
   logic Reset_n;
   int   checks;
   int   failures;
   int   wr_cnt_a;
   int   fd_cnt_a;
   int   se_cnt_a;
   logic [3:0] addr_q[$];

   uart_img_pack_wr_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
   uart_img_pack_wr_if #(.DATA_W(32), .ADDR_W(8)) ifb ();

   uart_img_pack_wr #(
      .DATA_W(16), .ADDR_W(4), .FRAME_WORDS(4), .MSB_FIRST(1'b1), .IDLE_TIMEOUT(100)
   ) dut_a (
      .Clk(clk), .Reset_n(Reset_n), .bus(ifa.slave)
   );

   uart_img_pack_wr #(
      .DATA_W(32), .ADDR_W(8), .FRAME_WORDS(16), .MSB_FIRST(1'b0), .IDLE_TIMEOUT(0)
   ) dut_b (
      .Clk(clk), .Reset_n(Reset_n), .bus(ifb.slave)
   );

   always #5 clk = ~clk;

   // Event log for instance A, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (ifa.ram_wr_en) begin
         wr_cnt_a++;
         addr_q.push_back(ifa.ram_wr_addr);
      end
      if (ifa.frame_done) fd_cnt_a++;
      if (ifa.sync_err) se_cnt_a++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the strobe was sampled.
   task automatic send_a(input logic [7:0] b, input logic with_clr);
      ifa.rx_data = b;
      ifa.Rx_Done = 1'b1;
      ifa.clr     = with_clr;
      @(negedge clk);
      ifa.Rx_Done = 1'b0;
      ifa.clr     = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      ifb.rx_data = b;
      ifb.Rx_Done = 1'b1;
      @(negedge clk);
      ifb.Rx_Done = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_addr [5];
      int w0;
      int fd0;
      exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      checks = 0; failures = 0; wr_cnt_a = 0; fd_cnt_a = 0; se_cnt_a = 0;
      clk = 1'b0; Reset_n = 1'b0;
      ifa.rx_data = '0; ifa.Rx_Done = 1'b0; ifa.clr = 1'b0;
      ifb.rx_data = '0; ifb.Rx_Done = 1'b0; ifb.clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en",  64'(ifa.ram_wr_en),   64'd0);
      chk("rst_addr",   64'(ifa.ram_wr_addr), 64'd0);
      chk("rst_data",   64'(ifa.ram_wr_data), 64'd0);
      chk("rst_fdone",  64'(ifa.frame_done),  64'd0);
      chk("rst_syncer", 64'(ifa.sync_err),    64'd0);
      chk("rst_busy",   64'(ifa.busy),        64'd0);
      chk("rst_b_data", 64'(ifb.ram_wr_data), 64'd0);
      Reset_n = 1'b1;
      @(negedge clk);

      // MSB-first pair
      send_a(8'hA5, 1'b0);
      chk("a5_no_wr", 64'(ifa.ram_wr_en), 64'd0);
      chk("a5_busy",  64'(ifa.busy),      64'd1);
      send_a(8'h3C, 1'b0);
      chk("a53c_wr",   64'(ifa.ram_wr_en),   64'd1);
      chk("a53c_addr", 64'(ifa.ram_wr_addr), 64'd0);
      chk("a53c_data", 64'(ifa.ram_wr_data), 64'hA53C);
      @(negedge clk);
      chk("a53c_pulse", 64'(ifa.ram_wr_en),   64'd0);
      chk("a53c_held",  64'(ifa.ram_wr_data), 64'hA53C);

      // LSB-first 32-bit word
      send_b(8'h11); chk("b1_no_wr", 64'(ifb.ram_wr_en), 64'd0);
      send_b(8'h22); chk("b2_no_wr", 64'(ifb.ram_wr_en), 64'd0);
      send_b(8'h33); chk("b3_no_wr", 64'(ifb.ram_wr_en), 64'd0);
      send_b(8'h44);
      chk("b4_wr",   64'(ifb.ram_wr_en),   64'd1);
      chk("b4_addr", 64'(ifb.ram_wr_addr), 64'd0);
      chk("b4_data", 64'(ifb.ram_wr_data), 64'h44332211);

      // Timeout on a word boundary: resync without sync_err
      repeat (110) @(negedge clk);
      chk("to0_busy",   64'(ifa.busy), 64'd0);
      chk("to0_no_err", 64'(se_cnt_a), 64'd0);

      // Full frame of 4 words plus one more
      addr_q.delete();
      fd0 = fd_cnt_a;
      for (int i = 0; i < 10; i++) begin
         send_a(8'(8'h10 + i), 1'b0);
         if (i == 7) begin
            chk("fr3_wr",    64'(ifa.ram_wr_en),   64'd1);
            chk("fr3_addr",  64'(ifa.ram_wr_addr), 64'd3);
            chk("fr3_data",  64'(ifa.ram_wr_data), 64'h1617);
            chk("fr3_fdone", 64'(ifa.frame_done),  64'd1);
            chk("fr3_busy",  64'(ifa.busy),        64'd0);
         end
         if (i == 8) chk("fr_busy_again", 64'(ifa.busy), 64'd1);
         if (i == 9) begin
            chk("fr4_addr",  64'(ifa.ram_wr_addr), 64'd0);
            chk("fr4_data",  64'(ifa.ram_wr_data), 64'h1819);
            chk("fr4_fdone", 64'(ifa.frame_done),  64'd0);
         end
      end
      @(negedge clk);
      chk("fr_nwrites", 64'(addr_q.size()), 64'd5);
      for (int i = 0; i < 5; i++) chk("fr_addr_seq", 64'(addr_q[i]), 64'(exp_addr[i]));
      chk("fr_fdone_cnt", 64'(fd_cnt_a - fd0), 64'd1);

      // Timeout with a partial word
      repeat (110) @(negedge clk);
      chk("to1_busy", 64'(ifa.busy), 64'd0);
      send_a(8'h20, 1'b0);
      send_a(8'h21, 1'b0);
      chk("p2021_addr", 64'(ifa.ram_wr_addr), 64'd0);
      chk("p2021_data", 64'(ifa.ram_wr_data), 64'h2021);
      send_a(8'h22, 1'b0);
      w0 = wr_cnt_a;
      repeat (99) @(negedge clk);
      chk("to_not_yet_busy", 64'(ifa.busy),     64'd1);
      chk("to_not_yet_err",  64'(ifa.sync_err), 64'd0);
      @(negedge clk);
      chk("to_sync_err", 64'(ifa.sync_err), 64'd1);
      chk("to_busy",     64'(ifa.busy),     64'd0);
      @(negedge clk);
      chk("to_err_pulse", 64'(ifa.sync_err),  64'd0);
      chk("to_no_write",  64'(wr_cnt_a - w0), 64'd0);
      chk("to_err_cnt",   64'(se_cnt_a),      64'd1);
      send_a(8'h30, 1'b0);
      send_a(8'h31, 1'b0);
      chk("p3031_addr", 64'(ifa.ram_wr_addr), 64'd0);
      chk("p3031_data", 64'(ifa.ram_wr_data), 64'h3031);
      send_a(8'h32, 1'b0);
      send_a(8'h33, 1'b0);
      chk("p3233_addr", 64'(ifa.ram_wr_addr), 64'd1);

      // Sync clear together with the second byte of a word
      send_a(8'h40, 1'b0);
      send_a(8'h41, 1'b1);
      chk("clr_no_wr",  64'(ifa.ram_wr_en), 64'd0);
      chk("clr_no_err", 64'(ifa.sync_err),  64'd0);
      chk("clr_busy",   64'(ifa.busy),      64'd0);
      repeat (3) @(negedge clk);
      chk("clr_addr_held", 64'(ifa.ram_wr_addr), 64'd1);
      chk("clr_data_held", 64'(ifa.ram_wr_data), 64'h3233);
      send_a(8'h50, 1'b0);
      send_a(8'h51, 1'b0);
      chk("p5051_wr",   64'(ifa.ram_wr_en),   64'd1);
      chk("p5051_addr", 64'(ifa.ram_wr_addr), 64'd0);
      chk("p5051_data", 64'(ifa.ram_wr_data), 64'h5051);

      // Reset in the middle of a word
      send_a(8'h60, 1'b0);
      Reset_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(ifa.busy),        64'd0);
      chk("mrst_addr", 64'(ifa.ram_wr_addr), 64'd0);
      chk("mrst_data", 64'(ifa.ram_wr_data), 64'd0);
      @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);
      send_a(8'hAA, 1'b0);
      send_a(8'h55, 1'b0);
      chk("paa55_wr",   64'(ifa.ram_wr_en),   64'd1);
      chk("paa55_addr", 64'(ifa.ram_wr_addr), 64'd0);
      chk("paa55_data", 64'(ifa.ram_wr_data), 64'hAA55);

      // Byte arriving exactly in the timeout cycle wins
      send_a(8'h70, 1'b0);
      repeat (99) @(negedge clk);
      send_a(8'h71, 1'b0);
      chk("race_wr",   64'(ifa.ram_wr_en),   64'd1);
      chk("race_addr", 64'(ifa.ram_wr_addr), 64'd1);
      chk("race_data", 64'(ifa.ram_wr_data), 64'h7071);
      chk("race_err",  64'(ifa.sync_err),    64'd0);
      @(negedge clk);
      chk("race_busy", 64'(ifa.busy), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
